// File: rtl/dm_ctrl.sv
// Word-organised data memory for the MEM stage: byte-lane stores, aligned/extended loads,
// alignment and range checking, one-cycle registered response, hardware zero sweep after reset.
module dm_ctrl #(
    parameter int          DEPTH     = 3072,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          TRACE     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err_align,
    output logic        rsp_err_range
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

    typedef enum logic {CLEAR, READY} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            err_align_q, err_align_d;
    logic            err_range_q, err_range_d;

    logic [31:0]     mem [DEPTH];

    logic [31:0]     offset;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic            align_err, range_err, accept, st_commit;
    logic [3:0]      be;
    logic [31:0]     wrep, rd_word, merged, ld_ext;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [31:0]     mem_wd;

    assign req_ready     = (state_q == READY);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err_align = err_align_q;
    assign rsp_err_range = err_range_q;

    always_comb begin
        offset    = req_addr - BASE_ADDR;
        idx       = offset[AW+1:2];
        lane      = req_addr[1:0];
        range_err = ({1'b0, offset} >= LIMIT);
        accept    = req_valid && req_ready;
        rd_word   = mem[idx];

        align_err = 1'b0;
        be        = 4'b1111;
        wrep      = req_wdata;
        case (req_size)
            2'd0: begin
                be   = 4'b0001 << lane;
                wrep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                align_err = lane[0];
                be        = 4'b0011 << lane;
                wrep      = {2{req_wdata[15:0]}};
            end
            2'd2:    align_err = (lane != 2'd0);
            default: align_err = 1'b1;
        endcase

        merged = rd_word;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : rd_word[8*i +: 8];

        case (lane)
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_size)
            2'd0:    ld_ext = {{24{req_signed & ld_byte[7]}}, ld_byte};
            2'd1:    ld_ext = {{16{req_signed & ld_half[15]}}, ld_half};
            default: ld_ext = rd_word;
        endcase

        st_commit = accept && req_we && !align_err && !range_err;

        // The sweep owns the write port until the last word is cleared.
        mem_we = (state_q == CLEAR) || st_commit;
        mem_wa = (state_q == CLEAR) ? cnt_q : idx;
        mem_wd = (state_q == CLEAR) ? 32'h0 : merged;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = accept;
        rsp_rdata_d = 32'h0;
        err_align_d = accept && align_err;
        err_range_d = accept && !align_err && range_err;
        if (accept && !req_we && !align_err && !range_err)
            rsp_rdata_d = ld_ext;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1))
                state_d = READY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            err_align_q <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_align_q <= err_align_d;
            err_range_q <= err_range_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

`ifndef SYNTHESIS
    if (TRACE) begin : g_trace
        always_ff @(posedge clk) begin
            if (st_commit)
                $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
        end
    end
`endif
endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: byte-addressed reference model checked every cycle, plus directed
// vectors with literal expectations.
module tb_dm_ctrl;
    localparam int DEPTH = 16;
    localparam int NB    = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, req_pc = 32'h0;
    logic        req_ready, rsp_valid, rsp_err_align, rsp_err_range;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int failures = 0;

    dm_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .TRACE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err_align(rsp_err_align), .rsp_err_range(rsp_err_range)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: memory as a flat byte array, accesses as byte runs.
    logic [7:0]  mbytes [NB];
    int          m_cycles;
    logic        e_valid, e_ea, e_er;
    logic [31:0] e_rdata;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
    endfunction

    function automatic bit misaligned(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd3) return 1'b1;
        return (a % nbytes(s)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic sg);
        logic [31:0] v = 32'h0;
        int n = nbytes(s);
        for (int k = 0; k < n; k++) v[8*k +: 8] = mbytes[int'(a) + k];
        if (sg && n < 4 && v[8*n-1])
            for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cycles <= 0;
            e_valid  <= 1'b0;
            e_rdata  <= 32'h0;
            e_ea     <= 1'b0;
            e_er     <= 1'b0;
            for (int i = 0; i < NB; i++) mbytes[i] <= 8'h00;
        end else begin
            if (m_cycles < DEPTH) m_cycles <= m_cycles + 1;
            e_valid <= 1'b0;
            e_rdata <= 32'h0;
            e_ea    <= 1'b0;
            e_er    <= 1'b0;
            if (m_cycles >= DEPTH && req_valid) begin
                e_valid <= 1'b1;
                if (misaligned(req_size, req_addr)) e_ea <= 1'b1;
                else if (req_addr >= NB) e_er <= 1'b1;
                else if (req_we)
                    for (int k = 0; k < nbytes(req_size); k++)
                        mbytes[int'(req_addr) + k] <= req_wdata[8*k +: 8];
                else e_rdata <= m_load(req_addr, req_size, req_signed);
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", {31'h0, req_ready}, {31'h0, m_cycles >= DEPTH});
        chk("valid", {31'h0, rsp_valid}, {31'h0, e_valid});
        if (e_valid) begin
            chk("rdata", rsp_rdata, e_rdata);
            chk("err_align", {31'h0, rsp_err_align}, {31'h0, e_ea});
            chk("err_range", {31'h0, rsp_err_range}, {31'h0, e_er});
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_pc = 32'h0040_0000 + a;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic release_and_count(input string name);
        int n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (req_ready) break;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    initial begin
        #3;
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_flags", {30'h0, rsp_err_align, rsp_err_range}, 32'h0);
        repeat (2) @(negedge clk);
        release_and_count("sweep_len");

        issue(0, 2'd2, 0, 32'h14, 0); idle();
        chk("clr_word5", rsp_rdata, 32'h0);
        chk("clr_word5_flags", {30'h0, rsp_err_align, rsp_err_range}, 32'h0);

        issue(1, 2'd2, 0, 32'h10, 32'h8badf00d);
        issue(1, 2'd0, 0, 32'h12, 32'h000000aa);
        issue(0, 2'd2, 0, 32'h10, 0); idle();
        chk("byte_merge", rsp_rdata, 32'h8baaf00d);
        issue(0, 2'd1, 1, 32'h12, 0); idle();
        chk("lh_hi", rsp_rdata, 32'hffff8baa);
        issue(0, 2'd0, 0, 32'h13, 0); idle();
        chk("lbu_3", rsp_rdata, 32'h0000008b);

        issue(1, 2'd1, 0, 32'h16, 32'hc3c3beef);
        issue(0, 2'd2, 0, 32'h14, 0); idle();
        chk("sh_hi", rsp_rdata, 32'hbeef0000);

        issue(1, 2'd2, 0, 32'h20, 32'h000080ff);
        issue(0, 2'd0, 1, 32'h20, 0); idle(); chk("lb",  rsp_rdata, 32'hffffffff);
        issue(0, 2'd0, 0, 32'h20, 0); idle(); chk("lbu", rsp_rdata, 32'h000000ff);
        issue(0, 2'd1, 1, 32'h20, 0); idle(); chk("lh",  rsp_rdata, 32'hffff80ff);
        issue(0, 2'd1, 0, 32'h20, 0); idle(); chk("lhu", rsp_rdata, 32'h000080ff);
        issue(0, 2'd2, 1, 32'h20, 0); idle(); chk("lw_sgn_ignored", rsp_rdata, 32'h000080ff);

        issue(1, 2'd1, 0, 32'h21, 32'h1111); idle();
        chk("sh_mis", {31'h0, rsp_err_align}, 32'h1);
        issue(1, 2'd2, 0, 32'h22, 32'h22222222); idle();
        chk("sw_mis", {31'h0, rsp_err_align}, 32'h1);
        issue(0, 2'd3, 0, 32'h20, 0); idle();
        chk("size3", {30'h0, rsp_err_align, rsp_err_range}, 32'h2);
        issue(0, 2'd2, 0, 32'h20, 0); idle();
        chk("mis_unchanged", rsp_rdata, 32'h000080ff);
        issue(0, 2'd2, 0, 32'h40, 0); idle();
        chk("range_flags", {30'h0, rsp_err_align, rsp_err_range}, 32'h1);
        chk("range_rdata", rsp_rdata, 32'h0);
        issue(0, 2'd2, 0, 32'hfffffffc, 0); idle();
        chk("range_wrap", {30'h0, rsp_err_align, rsp_err_range}, 32'h1);
        issue(0, 2'd1, 0, 32'h41, 0); idle();
        chk("align_prio", {30'h0, rsp_err_align, rsp_err_range}, 32'h2);

        issue(1, 2'd2, 0, 32'h30, 32'h12345678);
        issue(0, 2'd2, 0, 32'h30, 0); idle();
        chk("b2b_rdata", rsp_rdata, 32'h12345678);

        issue(1, 2'd2, 0, 32'h04, 32'h55555555);
        @(posedge clk);
        #2 rst_n = 1'b0; req_valid = 1'b0;
        #1 chk("rst_drop_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_drop_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("mid_sweep_ready", {31'h0, req_ready}, 32'h0);
        release_and_count("sweep_restart");

        issue(0, 2'd2, 0, 32'h10, 0); idle(); chk("post_rst_10", rsp_rdata, 32'h0);
        issue(0, 2'd2, 0, 32'h30, 0); idle(); chk("post_rst_30", rsp_rdata, 32'h0);
        issue(0, 2'd2, 0, 32'h04, 0); idle(); chk("post_rst_04", rsp_rdata, 32'h0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Parametrised data-memory controller for the MIPS pipeline's MEM stage: a word-organised RAM with internal byte-lane generation, load alignment and sign/zero extension, alignment/range checking and a one-cycle registered read. After reset it zeroes the whole array with a hardware sweep rather than a single-cycle clear. It replaces the fixed-depth, externally byte-enabled data memory and keeps the same store trace format.

## Interface
- DEPTH, 3072: memory size in 32-bit words; index width AW = $clog2(DEPTH).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- TRACE, 1: when 1, every committed store prints a simulation trace line.
---
- clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  controller can accept a request (0 during clear sweep).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_pc  input  32  PC of the instruction, used for the trace only.
- rsp_valid  output  1  response for the request accepted last cycle.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err_align  output  1  request was misaligned (or size 3).
- rsp_err_range  output  1  address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH).

## Operation
- States: CLEAR, READY. Reset asserted forces CLEAR with sweep counter = 0.
- CLEAR: writes 0 to word[counter] each cycle, counter increments; after writing word DEPTH-1 moves to READY. req_ready = 0; requests ignored, no response.
- READY: req_ready = 1; a request is accepted when req_valid && req_ready.
- Offset = req_addr - BASE_ADDR; index = offset[AW+1:2]; lane = req_addr[1:0].
- Align error: size 1 with lane[0] = 1; size 2 with lane != 0; size 3 always.
- Range error: offset >= 4*DEPTH (unsigned, so addresses below BASE_ADDR also fail). Align has priority; only one error flag set per response.
- Store byte enables: byte -> 4'b0001 << lane; half -> 4'b0011 << lane; word -> 4'b1111. Write data replicated across lanes (byte x4, half x2); only enabled lanes change. Errored stores write nothing.
- Load: whole word read; selected byte/half shifted down by lane, then sign- or zero-extended to 32 bits; word loads pass through (req_signed ignored).
- Trace (TRACE = 1, committed stores only): "%d@%h: *%h <= %h" with $time, req_pc, word-aligned byte address, full merged word after the write.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err_align 0, rsp_err_range 0; state CLEAR, counter 0.
- Clear sweep takes exactly DEPTH cycles after Reset deasserts; req_ready rises on the following cycle edge. Reset reasserted mid-sweep restarts the sweep from 0.
- Latency 1: request accepted at edge n -> rsp_valid = 1 with data/flags during cycle n+1, for loads and stores alike; rsp_valid = 0 in cycles with no accepted request. No response backpressure.
- Throughput one request per cycle. Store accepted at edge n followed by a load of the same word at edge n+1 returns the stored data at cycle n+2.
- Reset asserted with a response pending: response dropped, outputs return to reset values immediately.

## Test plan
- Reset release with DEPTH = 16 -> req_ready stays 0 for 16 cycles, then 1; load of word 5 returns 0x00000000 with no error flags.
- Store word 0x8badf00d at 0x10, then store byte 0xAA at 0x12 -> load word 0x10 returns 0x8baaf00d; two trace lines, second shows *00000010 <= 8baaf00d.
- Word 0x000080ff at 0x20: lb 0x20 -> 0xffffffff, lbu 0x20 -> 0x000000ff, lh 0x20 -> 0xffff80ff, lhu 0x20 -> 0x000080ff.
- Store half at 0x21 and word at 0x22 -> rsp_err_align = 1, memory unchanged, no trace; load at 4*DEPTH -> rsp_err_range = 1, rsp_rdata 0.
- Back-to-back store 0x12345678 to 0x30 and load 0x30 on consecutive cycles -> load response 0x12345678 one cycle after its acceptance.
- Assert Reset midway through traffic and mid-sweep -> rsp_valid drops immediately; full DEPTH-cycle sweep restarts; previously stored words read back 0.
